// File: rtl/em4100_reader_decoder_if.sv
// Envelope input and decoded-ID outputs of the EM4100 reader decoder.
// master = decoder side; slave = consumer that owns din and watches the strobes.
interface em4100_reader_decoder_if;
   logic        din;
   logic [39:0] id;
   logic        id_valid;
   logic        parity_err;
   logic        locked;
   logic        bit_valid;
   logic        bit_out;

   modport master (
      input  din,
      output id, id_valid, parity_err, locked, bit_valid, bit_out
   );

   modport slave (
      output din,
      input  id, id_valid, parity_err, locked, bit_valid, bit_out
   );
endinterface

// File: rtl/em4100_reader_decoder.sv
// EM4100 reader: Manchester run-length decode of din, 64-bit frame window, header/parity check.
// Latency din edge -> bit_valid 3 clks, last bit -> id_valid +1; no backpressure, all strobes 1 cycle.
module em4100_reader_decoder #(
   parameter int HALF_BIT_CLKS = 32,
   parameter int CNT_W         = $clog2(3*HALF_BIT_CLKS+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   em4100_reader_decoder_if.master   bus
);

   localparam logic [CNT_W-1:0] T_SHORT = CNT_W'(HALF_BIT_CLKS/2);
   localparam logic [CNT_W-1:0] T_LONG  = CNT_W'(3*HALF_BIT_CLKS/2);
   localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(5*HALF_BIT_CLKS/2);
   localparam logic [CNT_W-1:0] T_SAT   = CNT_W'(3*HALF_BIT_CLKS);

   localparam logic [1:0] S_UNLOCKED = 2'd0;
   localparam logic [1:0] S_MID      = 2'd1;
   localparam logic [1:0] S_BOUND    = 2'd2;

   logic             sync1, ds, ds_prev;
   logic             edge_seen;
   logic [CNT_W-1:0] cnt;
   logic             is_short, is_long, is_invalid;
   logic [1:0]       state, state_nxt;
   logic             emit;
   logic [63:0]      sr;
   logic [6:0]       fill;
   logic             bit_valid_q, bit_out_q;
   logic [39:0]      id_q;
   logic             id_valid_q, parity_err_q;
   logic [39:0]      id_cat;
   logic [3:0]       col_x;
   logic             row_ok, header_ok, parity_ok, check;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b0;
         ds      <= 1'b0;
         ds_prev <= 1'b0;
      end else begin
         sync1   <= bus.din;
         ds      <= sync1;
         ds_prev <= ds;
      end
   end

   assign edge_seen = ds ^ ds_prev;

   // Cycles since the last edge; the value seen on an edge is the run length.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (edge_seen)
         cnt <= CNT_W'(1);
      else if (cnt < T_SAT)
         cnt <= cnt + CNT_W'(1);
   end

   always_comb begin
      is_short   = edge_seen && (cnt >= T_SHORT) && (cnt < T_LONG);
      is_long    = edge_seen && (cnt >= T_LONG) && (cnt <= T_MAX);
      // A run that already exceeds the long limit is dead without waiting for its edge.
      is_invalid = edge_seen ? !(is_short || is_long) : (cnt > T_MAX);
   end

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      case (state)
         S_UNLOCKED: begin
            if (is_long) begin
               state_nxt = S_MID;
               emit      = 1'b1;
            end
         end
         S_MID: begin
            if (is_short)
               state_nxt = S_BOUND;
            else if (is_long)
               emit = 1'b1;
            else if (is_invalid)
               state_nxt = S_UNLOCKED;
         end
         S_BOUND: begin
            if (is_short) begin
               state_nxt = S_MID;
               emit      = 1'b1;
            end else if (is_long || is_invalid) begin
               state_nxt = S_UNLOCKED;
            end
         end
         default: state_nxt = S_UNLOCKED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_UNLOCKED;
         sr          <= '0;
         fill        <= '0;
         bit_valid_q <= 1'b0;
         bit_out_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_valid_q <= emit;
         if (emit)
            bit_out_q <= ds;
         if (state_nxt == S_UNLOCKED) begin
            fill <= '0;
         end else if (emit) begin
            sr <= {sr[62:0], ds};
            if (fill != 7'd64)
               fill <= fill + 7'd1;
         end
      end
   end

   // sr[63] is the oldest bit: 9 header ones, 10 rows of nibble+parity, 4 column parities, stop.
   always_comb begin
      id_cat = '0;
      col_x  = '0;
      row_ok = 1'b1;
      for (int r = 0; r < 10; r++) begin
         id_cat[39-4*r -: 4] = sr[54-5*r -: 4];
         col_x              ^= sr[54-5*r -: 4];
         if ((^sr[54-5*r -: 4]) != sr[50-5*r])
            row_ok = 1'b0;
      end
   end

   assign header_ok = (&sr[63:55]) && !sr[0];
   assign parity_ok = row_ok && (col_x == sr[4:1]);
   assign check     = bit_valid_q && (fill == 7'd64);

   always_ff @(posedge clk) begin
      if (rst) begin
         id_q         <= '0;
         id_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         id_valid_q   <= check && header_ok && parity_ok;
         parity_err_q <= check && header_ok && !parity_ok;
         if (check && header_ok && parity_ok)
            id_q <= id_cat;
      end
   end

   assign bus.id         = id_q;
   assign bus.id_valid   = id_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.locked     = (state != S_UNLOCKED);
   assign bus.bit_valid  = bit_valid_q;
   assign bus.bit_out    = bit_out_q;

endmodule
